// File: rtl/interboard_pkg.sv
// Shared definitions for the interboard link, used by both the transmitter and
// this receiver: message-type codes, field widths, beat count and the packed
// layout of the 24-bit packet word.
package interboard_pkg;

    localparam int BEATS  = 4;
    localparam int BEAT_W = 6;
    localparam int WORD_W = BEATS * BEAT_W;

    localparam int MSG_W  = 4;
    localparam int BX_W   = 5;
    localparam int BY_W   = 3;
    localparam int CARD_W = 6;
    localparam int SEL_W  = 3;
    localparam int DIR_W  = 1;
    localparam int PAD_W  = 2;

    // Message types carried in msg_type
    localparam logic [MSG_W-1:0] MSG_NONE    = 4'd0;
    localparam logic [MSG_W-1:0] MSG_SELECT  = 4'd1;
    localparam logic [MSG_W-1:0] MSG_MOVE    = 4'd2;
    localparam logic [MSG_W-1:0] MSG_PLACE   = 4'd3;
    localparam logic [MSG_W-1:0] MSG_DRAW    = 4'd4;
    localparam logic [MSG_W-1:0] MSG_DISCARD = 4'd5;
    localparam logic [MSG_W-1:0] MSG_UNDO    = 4'd6;
    localparam logic [MSG_W-1:0] MSG_WIN     = 4'd7;
    localparam logic [MSG_W-1:0] MSG_RESET   = 4'd8;

    // Packet word, MSB first; beat k carries bits [23-6k -: 6]
    typedef struct packed {
        logic [MSG_W-1:0]  msg_type;
        logic [BX_W-1:0]   block_x;
        logic [BY_W-1:0]   block_y;
        logic [CARD_W-1:0] card;
        logic [SEL_W-1:0]  sel_len;
        logic [DIR_W-1:0]  move_dir;
        logic [PAD_W-1:0]  pad;
    } ib_word_t;

    // Decoded fields presented to the rest of the board (pad is not exported)
    typedef struct packed {
        logic [MSG_W-1:0]  msg_type;
        logic [BX_W-1:0]   block_x;
        logic [BY_W-1:0]   block_y;
        logic [CARD_W-1:0] card;
        logic [SEL_W-1:0]  sel_len;
        logic [DIR_W-1:0]  move_dir;
    } ib_fields_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_EMIT
    } rx_state_e;

    // Even parity over the whole word: pad[0] is chosen so the XOR is zero
    function automatic logic word_parity_ok(input logic [WORD_W-1:0] w);
        return ~(^w);
    endfunction

endpackage

// File: rtl/interboard_sync.sv
// Multi-flop synchronizer bringing the peer's asynchronous request into clk.
module interboard_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous level through the flop chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the previous stage's old value, forming a true chain.
            sync_q[0] <= async_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/interboard_rx.sv
// Interboard receiver: four-phase Request/Ack handshake collecting four 6-bit
// beats into a 24-bit word, then decoding it into message fields.
// Optional feature: define INTERBOARD_PARITY_EN to reject words whose XOR is 1.
module interboard_rx
    import interboard_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Request_in,
    input  logic [BEAT_W-1:0] interboard_data_in,
    output logic              Ack_out,
    output logic              interboard_en,
    output logic [MSG_W-1:0]  interboard_msg_type,
    output logic [BX_W-1:0]   interboard_block_x,
    output logic [BY_W-1:0]   interboard_block_y,
    output logic [CARD_W-1:0] interboard_card,
    output logic [SEL_W-1:0]  interboard_sel_len,
    output logic              interboard_move_dir,
    output logic              rx_busy,
    output logic              rx_err
);

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic        req_s;
    rx_state_e   state_q;
    logic        ack_q;
    logic        en_q;
    logic        err_q;
    logic        block_q;      // set after a timeout until req_s is seen low
    logic [1:0]  beat_cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [WORD_W-1:0] shift_q;
    ib_fields_t  fields_q;
    ib_word_t    word;
    logic        word_ok;
    logic        handshake;
    logic        timeout_hit;

    interboard_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (Request_in),
        .sync_o  (req_s)
    );

    assign word = ib_word_t'(shift_q);

`ifdef INTERBOARD_PARITY_EN
    assign word_ok = word_parity_ok(shift_q);
`else
    assign word_ok = 1'b1;
`endif

    // The handshake edge the current wait state is looking for
    assign handshake   = (state_q == ST_WAIT_HI &&  req_s) ||
                         (state_q == ST_WAIT_LO && !req_s);
    assign timeout_hit = (state_q == ST_WAIT_HI || state_q == ST_WAIT_LO) &&
                         !handshake && (to_cnt_q == TO_LAST);

    // Handshake FSM with beat collection, timeout abort and decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            en_q       <= 1'b0;
            err_q      <= 1'b0;
            block_q    <= 1'b0;
            beat_cnt_q <= '0;
            to_cnt_q   <= '0;
            shift_q    <= '0;
            fields_q   <= '0;
        end else begin
            en_q  <= 1'b0;
            err_q <= 1'b0;
            if (!req_s) begin
                block_q <= 1'b0;
            end

            if (timeout_hit) begin
                // Drop the partial packet; a still-high request must fall first
                err_q      <= 1'b1;
                ack_q      <= 1'b0;
                beat_cnt_q <= '0;
                to_cnt_q   <= '0;
                block_q    <= req_s;
                state_q    <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE, ST_WAIT_HI: begin
                        if (req_s && !block_q) begin
                            shift_q    <= {shift_q[WORD_W-BEAT_W-1:0], interboard_data_in};
                            ack_q      <= 1'b1;
                            beat_cnt_q <= beat_cnt_q + 2'd1;
                            to_cnt_q   <= '0;
                            state_q    <= ST_WAIT_LO;
                        end else if (state_q == ST_WAIT_HI) begin
                            to_cnt_q <= to_cnt_q + TO_W'(1);
                        end
                    end
                    ST_WAIT_LO: begin
                        if (!req_s) begin
                            ack_q    <= 1'b0;
                            to_cnt_q <= '0;
                            if (beat_cnt_q == 2'd0) begin
                                // Decode is registered here so it lines up with EMIT
                                state_q <= ST_EMIT;
                                if (word_ok) begin
                                    en_q     <= 1'b1;
                                    fields_q <= '{msg_type: word.msg_type,
                                                  block_x:  word.block_x,
                                                  block_y:  word.block_y,
                                                  card:     word.card,
                                                  sel_len:  word.sel_len,
                                                  move_dir: word.move_dir};
                                end else begin
                                    err_q <= 1'b1;
                                end
                            end else begin
                                state_q <= ST_WAIT_HI;
                            end
                        end else begin
                            to_cnt_q <= to_cnt_q + TO_W'(1);
                        end
                    end
                    default: begin
                        to_cnt_q <= '0;
                        state_q  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign Ack_out             = ack_q;
    assign interboard_en       = en_q;
    assign rx_err              = err_q;
    assign rx_busy             = (state_q != ST_IDLE) || ack_q;
    assign interboard_msg_type = fields_q.msg_type;
    assign interboard_block_x  = fields_q.block_x;
    assign interboard_block_y  = fields_q.block_y;
    assign interboard_card     = fields_q.card;
    assign interboard_sel_len  = fields_q.sel_len;
    assign interboard_move_dir = fields_q.move_dir;

endmodule

// File: tb/tb_interboard_rx.sv
// Testbench for interboard_rx: random packets driven over the handshake,
// expected outcomes queued per packet and compared when the DUT pulses.
module tb_interboard_rx;

    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       Request_in;
    logic [5:0] data_in;
    logic       Ack_out;
    logic       interboard_en;
    logic [3:0] msg_type;
    logic [4:0] block_x;
    logic [2:0] block_y;
    logic [5:0] card;
    logic [2:0] sel_len;
    logic       move_dir;
    logic       rx_busy;
    logic       rx_err;

    typedef struct {
        logic [3:0] msg;
        logic [4:0] bx;
        logic [2:0] by;
        logic [5:0] card;
        logic [2:0] sel;
        logic       dir;
    } fld_t;

    typedef struct {
        bit   is_err;
        fld_t f;
    } exp_t;

    exp_t sb[$];
    fld_t last_good;
    fld_t zero_f;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [21:0] dut_f;

    interboard_rx #(.TIMEOUT_CYC(TO), .SYNC_STAGES(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .Request_in          (Request_in),
        .interboard_data_in  (data_in),
        .Ack_out             (Ack_out),
        .interboard_en       (interboard_en),
        .interboard_msg_type (msg_type),
        .interboard_block_x  (block_x),
        .interboard_block_y  (block_y),
        .interboard_card     (card),
        .interboard_sel_len  (sel_len),
        .interboard_move_dir (move_dir),
        .rx_busy             (rx_busy),
        .rx_err              (rx_err)
    );

    always #5 clk = ~clk;

    assign dut_f = {msg_type, block_x, block_y, card, sel_len, move_dir};

    function automatic logic [21:0] pack_f(input fld_t f);
        return {f.msg, f.bx, f.by, f.card, f.sel, f.dir};
    endfunction

    function automatic fld_t rand_f();
        fld_t f;
        f.msg  = 4'($urandom_range(0, 8));
        f.bx   = 5'($urandom);
        f.by   = 3'($urandom);
        f.card = 6'($urandom);
        f.sel  = 3'($urandom);
        f.dir  = 1'($urandom);
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},  Ack_out, 0);
        check({tag, "_en"},   interboard_en, 0);
        check({tag, "_err"},  rx_err, 0);
        check({tag, "_busy"}, rx_busy, 0);
        check({tag, "_msg"},  msg_type, 0);
        check({tag, "_bx"},   block_x, 0);
        check({tag, "_by"},   block_y, 0);
        check({tag, "_card"}, card, 0);
        check({tag, "_sel"},  sel_len, 0);
        check({tag, "_dir"},  move_dir, 0);
    endtask

    // One four-phase beat; data is noisy everywhere except around the request rise
    task automatic send_beat(input logic [5:0] v);
        int n;
        repeat ($urandom_range(0, 3)) begin
            data_in = 6'($urandom);
            @(negedge clk);
        end
        data_in = v;
        #2;
        Request_in = 1'b1;
        n = 0;
        while (!Ack_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!Ack_out) check("ack_rise_bound", Ack_out, 1);
        data_in = 6'($urandom);
        #3;
        Request_in = 1'b0;
        n = 0;
        while (Ack_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (Ack_out) check("ack_fall_bound", Ack_out, 0);
        data_in = 6'($urandom);
    endtask

    function automatic logic [23:0] make_word(input fld_t f, input logic [1:0] pad);
        return {f.msg, f.bx, f.by, f.card, f.sel, f.dir, pad};
    endfunction

    task automatic send_packet(input fld_t f, input logic [1:0] pad, input int nbeats);
        logic [23:0] w;
        exp_t e;
        w = make_word(f, pad);
        if (nbeats == 4) begin
            e.f = f;
`ifdef INTERBOARD_PARITY_EN
            e.is_err = ^w;
`else
            e.is_err = 1'b0;
`endif
            sb.push_back(e);
        end
        for (int k = 0; k < nbeats; k++) begin
            send_beat(w[23-6*k -: 6]);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
    endtask

    // Monitor: every pulse consumes one expected outcome
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (interboard_en || rx_err)) begin
            if (sb.size() == 0) begin
                check("pulse_with_nothing_expected", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("pulse_rx_err", rx_err, e.is_err);
                check("pulse_en", interboard_en, !e.is_err);
                if (e.is_err) begin
                    check("fields_held", dut_f, pack_f(last_good));
                end else begin
                    check("fields", dut_f, pack_f(e.f));
                    last_good = e.f;
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        fld_t f;
        exp_t e;
        int   n;
        zero_f    = '{msg: 0, bx: 0, by: 0, card: 0, sel: 0, dir: 0};
        last_good = zero_f;
        rst        = 1'b1;
        Request_in = 1'b0;
        data_in    = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed packet: beats 0E 0D 2A 15
        f = '{msg: 4'd3, bx: 5'd17, by: 3'd5, card: 6'd42, sel: 3'd2, dir: 1'b1};
        send_packet(f, 2'b01, 4);
        drain();

`ifdef INTERBOARD_PARITY_EN
        // Same packet with last beat 0x14: odd parity, must be rejected
        send_packet(f, 2'b00, 4);
        drain();
`endif

        // Random packets, some back-to-back
        for (int i = 0; i < 20; i++) begin
            send_packet(rand_f(), 2'($urandom), 4);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        // Two beats then silence: timeout after TO cycles in WAIT_HI
        e.is_err = 1'b1;
        e.f      = zero_f;
        sb.push_back(e);
        send_packet(rand_f(), 2'($urandom), 2);
        check("busy_mid_packet", rx_busy, 1);
        n = 0;
        while (!rx_err && n < TO + 20) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, TO);
        check("timeout_ack", Ack_out, 0);
        check("timeout_busy", rx_busy, 0);
        @(negedge clk);
        send_packet(rand_f(), 2'($urandom), 4);
        drain();

        // Reset after three beats discards the partial packet silently
        send_packet(rand_f(), 2'($urandom), 3);
        #3 rst = 1'b1;
        last_good = zero_f;
        #1 check_all_zero("midreset");
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        send_packet(rand_f(), 2'($urandom), 4);
        drain();

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
